// File: rtl/maxpool_pkg.sv
// Shared definitions for the max-pool layer sequencer: FSM state encoding,
// the drain timeout, and helpers that derive per-channel pixel and output counts
// from the module's map size and window size.
package maxpool_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLR    = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_NEXT   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    // Cycles to wait for the last pooled results before flagging an error.
    localparam int DRAIN_MAX = 4;

    // Input pixels per channel (PIX_PER_CH).
    function automatic int pix_per_ch(input int if_size);
        return if_size * if_size;
    endfunction

    // Pooled outputs per channel (OUT_PER_CH).
    function automatic int out_per_ch(input int if_size, input int p_size);
        return (if_size / p_size) * (if_size / p_size);
    endfunction

endpackage

// File: rtl/maxpool_sched_addrgen.sv
// Raster read-address generator for one channel of the max-pool sequencer.
// Tracks the column and linear pixel address (row*IF_SIZE+col kept incrementally),
// flags the final pixel, and with MAXPOOL_SCHED_ROWGAP_EN defined produces a
// one-cycle gap after the last read of every row.
module maxpool_sched_addrgen
    import maxpool_pkg::*;
#(
    parameter int IF_SIZE = 28,
    parameter int ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              adv,
    output logic [ADDR_W-1:0] addr,
    output logic              last_pix,
    output logic              gap,
    output logic              all_issued
);

    localparam int PIX_PER_CH = pix_per_ch(IF_SIZE);
    localparam int COL_W      = (IF_SIZE > 2) ? $clog2(IF_SIZE) : 1;

    logic [COL_W-1:0]  col_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              all_issued_reg;
    logic              row_end;

    assign row_end    = (col_reg == COL_W'(IF_SIZE - 1));
    assign last_pix   = (addr_reg == ADDR_W'(PIX_PER_CH - 1));
    assign addr       = addr_reg;
    assign all_issued = all_issued_reg;

    // Advance column/address on every issued read; park on the final pixel.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            col_reg        <= '0;
            addr_reg       <= '0;
            all_issued_reg <= 1'b0;
        end else if (adv) begin
            if (last_pix) begin
                all_issued_reg <= 1'b1;
            end else begin
                addr_reg <= addr_reg + ADDR_W'(1);
                col_reg  <= row_end ? '0 : col_reg + COL_W'(1);
            end
        end
    end

`ifdef MAXPOOL_SCHED_ROWGAP_EN
    logic gap_reg;

    // Block the read slot right after each row's last read.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            gap_reg <= 1'b0;
        end else begin
            gap_reg <= adv & row_end;
        end
    end

    assign gap = gap_reg;
`else
    assign gap = 1'b0;
`endif

endmodule

// File: rtl/maxpool_sched.sv
// Per-layer sequencer for the streaming 2x2 max-pool unit. Streams each
// channel's feature map from the layer buffer in raster order, drives the
// time-shared pool unit, and writes pooled results to the output buffer.
// Optional build macro: MAXPOOL_SCHED_ROWGAP_EN inserts a one-cycle read gap
// after the last pixel of every input row.
module maxpool_sched
    import maxpool_pkg::*;
#(
    parameter int BW      = 16,
    parameter int IF_SIZE = 28,
    parameter int P_SIZE  = 2,
    parameter int N_CH    = 3,
    parameter int ADDR_W  = 10,
    parameter int OADDR_W = 8,
    parameter int CH_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_hold,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err,
    output logic               o_rd_en,
    output logic [CH_W-1:0]    o_rd_ch,
    output logic [ADDR_W-1:0]  o_rd_addr,
    input  logic [BW-1:0]      i_rd_data,
    output logic               o_pool_rst,
    output logic               o_pool_ce,
    output logic [BW-1:0]      o_pool_data,
    input  logic [BW-1:0]      i_pool_data,
    input  logic               i_pool_valid,
    output logic               o_wr_en,
    output logic [CH_W-1:0]    o_wr_ch,
    output logic [OADDR_W-1:0] o_wr_addr,
    output logic [BW-1:0]      o_wr_data
);

    localparam int OUT_PER_CH = out_per_ch(IF_SIZE, P_SIZE);
    // One extra bit so the count can reach OUT_PER_CH itself.
    localparam int CNT_W      = OADDR_W + 1;

    state_t            state_reg, state_next;
    logic [CH_W-1:0]   ch_reg;
    logic [CNT_W-1:0]  wr_cnt_reg;
    logic [2:0]        drain_cnt_reg;
    logic              err_reg;
    logic              ce_reg;

    logic              rd_en;
    logic              stream_end;
    logic              wr_full;
    logic              drain_timeout;
    logic              pool_hit;
    logic              wr_en;
    logic              start_ok;
    logic [ADDR_W-1:0] rd_addr;
    logic              last_pix;
    logic              gap;
    logic              all_issued;

    maxpool_sched_addrgen #(
        .IF_SIZE (IF_SIZE),
        .ADDR_W  (ADDR_W)
    ) u_addrgen (
        .clk        (clk),
        .rst        (rst),
        .clr        (state_reg == ST_CLR),
        .adv        (rd_en),
        .addr       (rd_addr),
        .last_pix   (last_pix),
        .gap        (gap),
        .all_issued (all_issued)
    );

    assign start_ok      = (state_reg == ST_IDLE) && i_start;
    assign rd_en         = (state_reg == ST_STREAM) && !i_hold && !gap && !all_issued;
    assign wr_full       = (wr_cnt_reg == CNT_W'(OUT_PER_CH));
    assign drain_timeout = (drain_cnt_reg == 3'(DRAIN_MAX - 1)) && !wr_full;
    assign pool_hit      = i_pool_valid && ce_reg;
    // Results beyond one channel's output count are dropped, not written.
    assign wr_en         = pool_hit && !wr_full;

`ifdef MAXPOOL_SCHED_ROWGAP_EN
    // The final read is followed by its row gap cycle before leaving STREAM.
    assign stream_end = all_issued;
`else
    assign stream_end = rd_en && last_pix;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:   if (i_start) state_next = ST_CLR;
            ST_CLR:    state_next = ST_STREAM;
            ST_STREAM: if (stream_end) state_next = ST_DRAIN;
            ST_DRAIN:  if (wr_full || drain_timeout) state_next = ST_NEXT;
            ST_NEXT:   state_next = (ch_reg == CH_W'(N_CH - 1)) ? ST_DONE : ST_CLR;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Channel index: zeroed on accepted start, stepped between channels.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            ch_reg <= '0;
        end else if (state_reg == ST_NEXT && ch_reg != CH_W'(N_CH - 1)) begin
            ch_reg <= ch_reg + CH_W'(1);
        end
    end

    // Output write counter, restarted for every channel.
    always_ff @(posedge clk) begin
        if (rst || state_reg == ST_CLR) begin
            wr_cnt_reg <= '0;
        end else if (wr_en) begin
            wr_cnt_reg <= wr_cnt_reg + CNT_W'(1);
        end
    end

    // Cycles spent in DRAIN, bounding the wait for trailing results.
    always_ff @(posedge clk) begin
        if (rst || state_reg != ST_DRAIN) begin
            drain_cnt_reg <= '0;
        end else begin
            drain_cnt_reg <= drain_cnt_reg + 3'd1;
        end
    end

    // Sticky error: missing results at drain timeout or surplus results.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            err_reg <= 1'b0;
        end else if ((state_reg == ST_DRAIN && drain_timeout) || (pool_hit && wr_full)) begin
            err_reg <= 1'b1;
        end
    end

    // Pool enable follows the read strobe by one cycle, lining up with read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            ce_reg <= 1'b0;
        end else begin
            ce_reg <= rd_en;
        end
    end

    assign o_busy      = (state_reg != ST_IDLE);
    assign o_done      = (state_reg == ST_DONE);
    assign o_err       = err_reg;
    assign o_rd_en     = rd_en;
    assign o_rd_ch     = ch_reg;
    assign o_rd_addr   = rd_addr;
    assign o_pool_rst  = (state_reg == ST_CLR);
    assign o_pool_ce   = ce_reg;
    // The buffer registers its read data; it is valid exactly in the ce cycle.
    assign o_pool_data = ce_reg ? i_rd_data : '0;
    assign o_wr_en     = wr_en;
    assign o_wr_ch     = ch_reg;
    assign o_wr_addr   = wr_cnt_reg[OADDR_W-1:0];
    assign o_wr_data   = wr_en ? i_pool_data : '0;

endmodule
